// File: rtl/vga_timing_pkg.sv
// Shared 640x480 @ 60 Hz VGA timing constants and coordinate type.
// Object renderers import this package for their screen-size bounds.
package vga_timing_pkg;

    // Every raster coordinate is 10 bits wide, so totals must not exceed 1024.
    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    // Horizontal timing, in pixels.
    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;

    // Vertical timing, in lines.
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    // System clocks per pixel: 50 MHz system clock down to a 25 MHz pixel rate.
    localparam int DEF_TICK_DIV  = 2;

    // Derived totals: 800 pixels per line, 525 lines per frame.
    localparam int DEF_H_TOTAL = DEF_H_DISPLAY + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_DISPLAY + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Inclusive sync windows: hsync over 656..751, vsync over 490..491.
    localparam int DEF_H_SYNC_START = DEF_H_DISPLAY + DEF_H_FP;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
    localparam int DEF_V_SYNC_START = DEF_V_DISPLAY + DEF_V_FP;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

    // Inclusive range test used for the sync window decodes.
    function automatic logic inRange(input coord_t value, input coord_t lo, input coord_t hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-rate strobe: divides the system clock by TICK_DIV and produces a
// one-clk pulse in the cycle where the divider sits at its last count.
module pixel_tick_gen #(
    parameter int TICK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic pixel_tick
);

    // A divider of at least 2 always needs at least one bit.
    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] divCount_q;
    logic [CNT_W-1:0] divCount_d;
    logic             tick_q;
    logic             tick_d;

    // Next divider value and whether that value is the pixel-tick count.
    always_comb begin
        divCount_d = divCount_q + 1'b1;
        if (divCount_q == DIV_LAST) begin
            divCount_d = '0;
        end
        tick_d = (divCount_d == DIV_LAST);
    end

    // The strobe is registered alongside the divider so it is high exactly
    // while the divider holds its last count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divCount_q <= '0;
            tick_q     <= 1'b0;
        end else begin
            divCount_q <= divCount_d;
            tick_q     <= tick_d;
        end
    end

    assign pixel_tick = tick_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator. Produces the pixel coordinates, active-low
// sync pins, the visible-area qualifier and a frame-start strobe, all
// registered and aligned to the same clock edge.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int TICK_DIV  = DEF_TICK_DIV
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] HCount,
    output logic [9:0] VCount,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       pixel_tick,
    output logic       frame_start
);

    // Totals and decode boundaries for this instance's geometry.
    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST    = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST    = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VISIBLE = coord_t'(H_DISPLAY);
    localparam coord_t V_VISIBLE = coord_t'(V_DISPLAY);
    localparam coord_t H_SYNC_LO = coord_t'(H_DISPLAY + H_FP);
    localparam coord_t H_SYNC_HI = coord_t'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam coord_t V_SYNC_LO = coord_t'(V_DISPLAY + V_FP);
    localparam coord_t V_SYNC_HI = coord_t'(V_DISPLAY + V_FP + V_SYNC - 1);

    logic   pixelTick;

    coord_t hCount_q;
    coord_t hCount_d;
    coord_t vCount_q;
    coord_t vCount_d;
    logic   hLast;
    logic   vLast;

    logic   hsync_q;
    logic   hsync_d;
    logic   vsync_q;
    logic   vsync_d;
    logic   videoOn_q;
    logic   videoOn_d;
    logic   frameStart_q;
    logic   frameStart_d;

    pixel_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_pixel_tick_gen (
        .clk        (clk),
        .reset      (reset),
        .pixel_tick (pixelTick)
    );

    // Raster counter advance: move one pixel per tick, wrapping the line at
    // the horizontal total and the frame at the vertical total.
    always_comb begin
        hLast    = (hCount_q == H_LAST);
        vLast    = (vCount_q == V_LAST);
        hCount_d = hCount_q;
        vCount_d = vCount_q;
        if (pixelTick) begin
            if (hLast) begin
                hCount_d = '0;
                if (vLast) begin
                    vCount_d = '0;
                end else begin
                    vCount_d = vCount_q + 1'b1;
                end
            end else begin
                hCount_d = hCount_q + 1'b1;
            end
        end
    end

    // Sync and blanking decode from the next coordinates, so the registered
    // qualifiers always describe the coordinates presented alongside them.
    always_comb begin
        hsync_d      = !inRange(hCount_d, H_SYNC_LO, H_SYNC_HI);
        vsync_d      = !inRange(vCount_d, V_SYNC_LO, V_SYNC_HI);
        videoOn_d    = (hCount_d < H_VISIBLE) && (vCount_d < V_VISIBLE);
        frameStart_d = pixelTick && hLast && vLast;
    end

    // Output registers; the reset state is the (0,0) pixel with syncs idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hCount_q     <= '0;
            vCount_q     <= '0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            videoOn_q    <= 1'b1;
            frameStart_q <= 1'b0;
        end else begin
            hCount_q     <= hCount_d;
            vCount_q     <= vCount_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            videoOn_q    <= videoOn_d;
            frameStart_q <= frameStart_d;
        end
    end

    assign HCount      = hCount_q;
    assign VCount      = vCount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = videoOn_q;
    assign pixel_tick  = pixelTick;
    assign frame_start = frameStart_q;

endmodule
